// File: rtl/screen_mapper.sv
// Two-stage world-to-screen mapper: scale/offset, then flip, range check and output register.
// Define SCREEN_MAPPER_CLAMP_EN to clamp out-of-range points (m_clip=1) instead of dropping them.
module screen_mapper #(
  parameter int IN_W      = 12,
  parameter int SCALE_W   = 8,
  parameter int FRAC_BITS = 4,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int CNT_W     = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          cfg_we,
  input  logic [SCALE_W-1:0]            cfg_scale,
  input  logic signed [IN_W:0]          cfg_x_off,
  input  logic signed [IN_W:0]          cfg_y_off,
  input  logic                          cfg_flip_y,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [IN_W-1:0]        s_x,
  input  logic signed [IN_W-1:0]        s_y,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(SCREEN_W)-1:0]   m_x,
  output logic [$clog2(SCREEN_H)-1:0]   m_y,
  output logic                          m_clip,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int PW = IN_W + SCALE_W + 2;
  localparam logic signed [PW-1:0] SW_S = PW'(SCREEN_W);
  localparam logic signed [PW-1:0] SH_S = PW'(SCREEN_H);
  localparam logic signed [PW-1:0] H1_S = PW'(SCREEN_H - 1);

  logic [SCALE_W-1:0]   scale_r;
  logic signed [IN_W:0] xoff_r, yoff_r;
  logic                 flip_r;

  logic                 v1, flip1;
  logic signed [PW-1:0] px1, py1;

  logic en1, en2;
  logic signed [PW-1:0] sx_e, sy_e, sc_e, xoff_e, yoff_e, xprod, yprod, px_n, py_n;
  logic signed [PW-1:0] pyf;
  logic x_in, y_in, in_range;

  assign en2     = !m_valid || m_ready;
  assign en1     = !v1 || en2;
  assign s_ready = en1;

  // Operands are widened into signed variables first so >>> stays arithmetic (floor).
  always_comb begin
    sx_e   = {{(PW-IN_W){s_x[IN_W-1]}}, s_x};
    sy_e   = {{(PW-IN_W){s_y[IN_W-1]}}, s_y};
    sc_e   = {{(PW-SCALE_W){1'b0}}, scale_r};
    xoff_e = {{(PW-IN_W-1){xoff_r[IN_W]}}, xoff_r};
    yoff_e = {{(PW-IN_W-1){yoff_r[IN_W]}}, yoff_r};
    xprod  = sx_e * sc_e;
    yprod  = sy_e * sc_e;
    px_n   = (xprod >>> FRAC_BITS) + xoff_e;
    py_n   = (yprod >>> FRAC_BITS) + yoff_e;
  end

  always_comb begin
    pyf      = flip1 ? (H1_S - py1) : py1;
    x_in     = !px1[PW-1] && (px1 < SW_S);
    y_in     = !pyf[PW-1] && (pyf < SH_S);
    in_range = x_in && y_in;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      scale_r <= SCALE_W'(1 << FRAC_BITS);
      xoff_r  <= '0;
      yoff_r  <= '0;
      flip_r  <= 1'b0;
    end else if (cfg_we) begin
      scale_r <= cfg_scale;
      xoff_r  <= cfg_x_off;
      yoff_r  <= cfg_y_off;
      flip_r  <= cfg_flip_y;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      v1    <= 1'b0;
      flip1 <= 1'b0;
      px1   <= '0;
      py1   <= '0;
    end else if (en1) begin
      v1 <= s_valid;
      if (s_valid) begin
        px1   <= px_n;
        py1   <= py_n;
        flip1 <= flip_r;
      end
    end
  end

`ifdef SCREEN_MAPPER_CLAMP_EN
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  always_comb begin
    cx = px1[PW-1] ? '0 : (x_in ? px1[XW-1:0] : XW'(SCREEN_W - 1));
    cy = pyf[PW-1] ? '0 : (y_in ? pyf[YW-1:0] : YW'(SCREEN_H - 1));
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_valid    <= 1'b0;
      m_x        <= '0;
      m_y        <= '0;
      m_clip     <= 1'b0;
      drop_count <= '0;
    end else if (en2) begin
      m_valid <= v1;
      if (v1) begin
        m_x    <= cx;
        m_y    <= cy;
        m_clip <= !in_range;
      end
    end
  end
`else
  assign m_clip = 1'b0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_valid    <= 1'b0;
      m_x        <= '0;
      m_y        <= '0;
      drop_count <= '0;
    end else if (en2) begin
      m_valid <= v1 && in_range;
      if (v1 && in_range) begin
        m_x <= px1[XW-1:0];
        m_y <= pyf[YW-1:0];
      end
      if (v1 && !in_range && (drop_count != '1))
        drop_count <= drop_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_screen_mapper.sv
// Bench for screen_mapper: directed steps plus randomized traffic against an arithmetic reference queue.
module tb_screen_mapper;
  localparam int IN_W = 12, SCALE_W = 8, FRAC_BITS = 4, SW = 640, SH = 480, CNT_W = 16;
  localparam int DEN = 1 << FRAC_BITS;

  logic ACLK, ARESETn;
  logic cfg_we, cfg_flip_y;
  logic [SCALE_W-1:0] cfg_scale;
  logic signed [IN_W:0] cfg_x_off, cfg_y_off;
  logic s_valid, s_ready, m_valid, m_ready, m_clip;
  logic signed [IN_W-1:0] s_x, s_y;
  logic [9:0] m_x;
  logic [8:0] m_y;
  logic [CNT_W-1:0] drop_count;

  screen_mapper #(
    .IN_W(IN_W), .SCALE_W(SCALE_W), .FRAC_BITS(FRAC_BITS),
    .SCREEN_W(SW), .SCREEN_H(SH), .CNT_W(CNT_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cfg_we(cfg_we), .cfg_scale(cfg_scale),
    .cfg_x_off(cfg_x_off), .cfg_y_off(cfg_y_off), .cfg_flip_y(cfg_flip_y),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_clip(m_clip), .drop_count(drop_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct { int x; int y; bit clip; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, mdrop = 0, n_out = 0;
  int msc = DEN, mxo = 0, myo = 0;
  bit mfl = 1'b0, hold = 1'b0, saw_block = 1'b0;
  logic [9:0] hx;
  logic [8:0] hy;
  logic hc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int p);
    return (p >= 0) ? p / DEN : -((-p + DEN - 1) / DEN);
  endfunction

  // Reference: real-number floor of x*scale, offset, flip, then keep/clamp/drop.
  function automatic void predict(input int x, input int y);
    int px, py;
    bit inr;
    exp_t e;
    px = fdiv(x * msc) + mxo;
    py = fdiv(y * msc) + myo;
    if (mfl) py = SH - 1 - py;
    inr = (px >= 0) && (px < SW) && (py >= 0) && (py < SH);
`ifdef SCREEN_MAPPER_CLAMP_EN
    e.x = (px < 0) ? 0 : (px > SW - 1) ? SW - 1 : px;
    e.y = (py < 0) ? 0 : (py > SH - 1) ? SH - 1 : py;
    e.clip = !inr;
    q.push_back(e);
`else
    if (inr) begin
      e.x = px; e.y = py; e.clip = 1'b0;
      q.push_back(e);
    end else if (mdrop < (1 << CNT_W) - 1) begin
      mdrop++;
    end
`endif
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        q.delete(); mdrop = 0; msc = DEN; mxo = 0; myo = 0; mfl = 1'b0; hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_x", m_x, hx);
          chk("hold_y", m_y, hy);
          chk("hold_clip", m_clip, hc);
        end
        if (m_valid && m_ready) begin
          if (q.size() == 0) chk("unexpected_out", m_valid, 0);
          else begin
            e = q.pop_front();
            chk("out_x", m_x, e.x);
            chk("out_y", m_y, e.y);
            chk("out_clip", m_clip, e.clip);
            n_out++;
          end
        end
        hold = m_valid && !m_ready;
        hx = m_x; hy = m_y; hc = m_clip;
        if (!s_ready) saw_block = 1'b1;
        if (s_valid && s_ready) predict(int'(s_x), int'(s_y));
        if (cfg_we) begin
          msc = cfg_scale; mxo = cfg_x_off; myo = cfg_y_off; mfl = cfg_flip_y;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input int x, input int y);
    int n = 0;
    s_valid = 1'b1; s_x = IN_W'(x); s_y = IN_W'(y);
    @(negedge ACLK);
    while (!s_ready && n < 50) begin n++; @(negedge ACLK); end
    if (n >= 50) chk("send_timeout", s_ready, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic cfg(input int sc, input int xo, input int yo, input bit fl);
    cfg_we = 1'b1; cfg_scale = SCALE_W'(sc);
    cfg_x_off = (IN_W+1)'(xo); cfg_y_off = (IN_W+1)'(yo); cfg_flip_y = fl;
    @(posedge ACLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int ex, input int ey, input bit ec);
    int n = 0;
    @(negedge ACLK);
    while (!(m_valid && m_ready) && n < 20) begin n++; @(negedge ACLK); end
    if (n >= 20) chk({tag, "_timeout"}, m_valid, 1);
    chk({tag, "_x"}, m_x, ex);
    chk({tag, "_y"}, m_y, ey);
    chk({tag, "_clip"}, m_clip, ec);
    @(posedge ACLK); #1;
  endtask

  initial begin
    int n0, rx, ry, ro1, ro2;
    bit acc;
    ARESETn = 1'b1; cfg_we = 1'b0; cfg_scale = 8'd16; cfg_x_off = '0; cfg_y_off = '0;
    cfg_flip_y = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b1;
    #1 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_x", m_x, 0);
    chk("rst_m_y", m_y, 0);
    chk("rst_m_clip", m_clip, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_s_ready", s_ready, 1);

    send(100, 50);
    s_valid = 1'b0;
    chk("lat_early", m_valid, 0);
    @(posedge ACLK); #1;
    chk("lat_valid", m_valid, 1);
    chk("basic_x", m_x, 100);
    chk("basic_y", m_y, 50);
    chk("basic_clip", m_clip, 0);
    chk("basic_drop", drop_count, 0);
    repeat (2) @(posedge ACLK); #1;

    cfg(24, 10, -5, 1'b0);
    send(-3, 7); s_valid = 1'b0;
    wait_out("scale15", 5, 5, 1'b0);
    cfg(32, 10, -5, 1'b0);
    send(-3, 7); s_valid = 1'b0;
    wait_out("scale2", 4, 9, 1'b0);

    cfg(16, 0, 0, 1'b1);
    send(0, 0); send(639, 479); s_valid = 1'b0;
    wait_out("flip_a", 0, 479, 1'b0);
    wait_out("flip_b", 639, 0, 1'b0);

    cfg(16, 0, 0, 1'b0);
`ifdef SCREEN_MAPPER_CLAMP_EN
    send(700, -2); s_valid = 1'b0;
    wait_out("clamp", 639, 0, 1'b1);
    chk("clamp_drop", drop_count, 0);
`else
    send(640, 0); send(0, -1); send(639, 479); s_valid = 1'b0;
    wait_out("edge_keep", 639, 479, 1'b0);
    chk("edge_drop", drop_count, 2);
`endif

    n0 = n_out; saw_block = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i * 10, i * 5);
        s_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge ACLK);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge ACLK);
        #1 m_ready = 1'b1;
      end
    join
    repeat (6) @(posedge ACLK); #1;
    chk("stream_count", n_out - n0, 8);
    chk("stream_blocked", saw_block, 1);
    chk("stream_empty", q.size(), 0);

    m_ready = 1'b0;
    send(1, 1); send(2, 2); s_valid = 1'b0;
    ARESETn = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_drop", drop_count, 0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1; m_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(posedge ACLK); #1;
    chk("postrst_valid", m_valid, 0);
    chk("postrst_count", n_out - n0, 0);
    chk("postrst_drop", drop_count, 0);

    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge ACLK);
      acc = s_valid && s_ready;
      @(posedge ACLK); #1;
      if (!s_valid || acc) begin
        rx = int'($urandom_range(0, 800)) - 80;
        ry = int'($urandom_range(0, 640)) - 80;
        s_valid = ($urandom_range(0, 3) != 0);
        s_x = IN_W'(rx); s_y = IN_W'(ry);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 15) == 0);
      if (cfg_we) begin
        ro1 = int'($urandom_range(0, 120)) - 60;
        ro2 = int'($urandom_range(0, 120)) - 60;
        cfg_scale = SCALE_W'($urandom_range(4, 40));
        cfg_x_off = (IN_W+1)'(ro1);
        cfg_y_off = (IN_W+1)'(ro2);
        cfg_flip_y = $urandom_range(0, 1) != 0;
      end
    end
    s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1;
    repeat (8) @(posedge ACLK); #1;
    chk("rand_drain", q.size(), 0);
    chk("rand_drop", drop_count, mdrop);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/screen_mapper.md
Name: screen_mapper

Overview:
- Parametrised, pipelined world-to-screen coordinate mapper for the graphics pipeline; successor to the fixed 8-bit coordinate pass-through.
- Takes signed world (x,y) points, applies a runtime fixed-point scale, viewport offset and optional Y flip, range-checks against screen size, and emits unsigned screen coordinates.
- Valid/ready on both sides; sits between the primitive generator and the framebuffer writer.

Parameters:
- IN_W, 12, signed world coordinate width (two's complement)
- SCALE_W, 8, unsigned scale factor width
- FRAC_BITS, 4, fractional bits of scale (scale 2^FRAC_BITS = 1.0)
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels
- CNT_W, 16, drop counter width

Ports:
- ACLK  in  1  clock, all state on rising edge
- ARESETn  in  1  asynchronous active-low reset
- cfg_we  in  1  latch cfg_* into configuration registers this cycle
- cfg_scale  in  SCALE_W  unsigned fixed-point scale
- cfg_x_off  in  IN_W+1  signed X offset
- cfg_y_off  in  IN_W+1  signed Y offset
- cfg_flip_y  in  1  1 = screen Y origin at bottom
- s_valid  in  1  input point valid
- s_ready  out  1  input point accepted when s_valid & s_ready
- s_x, s_y  in  IN_W  signed world coordinates
- m_valid  out  1  output point valid
- m_ready  in  1  downstream accepts
- m_x  out  clog2(SCREEN_W)  screen X
- m_y  out  clog2(SCREEN_H)  screen Y
- m_clip  out  1  point was clamped (constant 0 without macro)
- drop_count  out  CNT_W  saturating count of dropped points

Behaviour:
- Reset (async assert, sync release): config regs scale=2^FRAC_BITS, offsets=0, flip=0; stage valids v1=v2=0; m_valid=0, m_x=m_y=0, m_clip=0, drop_count=0; s_ready=1 on first cycle after release.
- Config: cfg_we captures all cfg_* on that edge; points accepted on the same edge use OLD config; later points use new. Points in flight are unaffected.
- Stage 1 (on accept): px = (s_x * scale) >>> FRAC_BITS + x_off; same for Y. Arithmetic shift = floor (rounds toward -inf). Intermediate width IN_W+SCALE_W+2 signed, no overflow possible. Flip flag captured with point.
- Stage 2: if flip, py' = SCREEN_H-1 - py, else py' = py. In range iff 0 <= px < SCREEN_W and 0 <= py' < SCREEN_H. In-range: load m_x/m_y, set m_valid.
- Out-of-range (no macro): point discarded, not presented, drop_count += 1, saturating at 2^CNT_W-1.
- Flow control: en2 = !v2 | m_ready; en1 = !v1 | en2; s_ready = en1. Stage advances only when its enable is high. Latency 2 cycles accept-to-m_valid; throughput 1 point/cycle with m_ready=1.
- m_x/m_y/m_clip hold stable while m_valid & !m_ready. No point lost, duplicated or reordered under any backpressure pattern.
- A dropped point in stage 2 leaves m_valid=0 for that slot (bubble); drop and acceptance of a new stage-1 point may coincide.
- Reset mid-stream: all in-flight points discarded; drop_count cleared.

Optional Feature:
- Macro SCREEN_MAPPER_CLAMP_EN.
- Defined: out-of-range points are not dropped; px clamped to [0, SCREEN_W-1], py' clamped to [0, SCREEN_H-1]; emitted with m_clip=1; drop_count stays 0.
- Undefined: drop behaviour above; m_clip tied 0.

Test Plan:
- Reset, defaults, send (100,50) with m_ready=1 -> m_valid two cycles later, m_x=100, m_y=50, m_clip=0, drop_count=0.
- cfg scale=24 (1.5), x_off=10, y_off=-5; send (-3,7) -> -72>>>4=-5, m=(5,5); scale=32, send (-3,7) -> (4,9).
- cfg_flip_y=1, offsets 0, scale 16; send (0,0) -> (0,479); send (639,479) -> (639,0).
- No macro: send (640,0), (0,-1), (639,479) -> only (639,479) emitted, drop_count=2. With SCREEN_MAPPER_CLAMP_EN: (700,-2) -> (639,0) m_clip=1.
- Stream points 1..8 continuously, m_ready low 5 cycles mid-stream -> s_ready low after stage fill, outputs held stable, all 8 emitted in order, no duplicates.
- Assert ARESETn low with 2 points in flight -> m_valid=0 immediately, after release no stale point emitted, drop_count=0.
